// File: rtl/axi_slave_mem.sv
// AXI4 burst slave over a byte-writable word memory, plus a backdoor word-load port.
// Latency: first R beat C_RD_LATENCY cycles after AR accept, then one beat per cycle; W beats written on acceptance.
// Backpressure: RREADY low freezes the presented beat; BREADY low holds the write response; one burst per direction.
module axi_slave_mem #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_MEM_DEPTH      = 1024,
    parameter int C_RD_LATENCY     = 1,
    localparam int AW = (C_MEM_DEPTH > 1) ? $clog2(C_MEM_DEPTH) : 1,
    localparam int SB = C_AXI_DATA_WIDTH / 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [31:0]                 S_AXI_AWADDR,
    input  logic [7:0]                  S_AXI_AWLEN,
    input  logic [1:0]                  S_AXI_AWBURST,
    input  logic                        S_AXI_AWVALID,
    output logic                        S_AXI_AWREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
    input  logic [SB-1:0]               S_AXI_WSTRB,
    input  logic                        S_AXI_WLAST,
    input  logic                        S_AXI_WVALID,
    output logic                        S_AXI_WREADY,
    output logic [1:0]                  S_AXI_BRESP,
    output logic                        S_AXI_BVALID,
    input  logic                        S_AXI_BREADY,
    input  logic [31:0]                 S_AXI_ARADDR,
    input  logic [7:0]                  S_AXI_ARLEN,
    input  logic [1:0]                  S_AXI_ARBURST,
    input  logic                        S_AXI_ARVALID,
    output logic                        S_AXI_ARREADY,
    output logic [C_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
    output logic [1:0]                  S_AXI_RRESP,
    output logic                        S_AXI_RLAST,
    output logic                        S_AXI_RVALID,
    input  logic                        S_AXI_RREADY,
    input  logic                        LOAD_EN,
    input  logic [AW-1:0]               LOAD_ADDR,
    input  logic [C_AXI_DATA_WIDTH-1:0] LOAD_DATA
);

    localparam int         OFFS        = $clog2(SB);
    localparam logic [2:0] WAIT_INIT   = (C_RD_LATENCY > 1) ? 3'(C_RD_LATENCY - 2) : 3'd0;
    localparam logic [31:0] DEPTH_W    = 32'(C_MEM_DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

    logic [C_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];

    // Word index of the beat after idx; unsupported WRAP lengths fall back to INCR.
    function automatic logic [31:0] next_idx(input logic [31:0] idx, input logic [7:0] len,
                                             input logic [1:0] burst);
        logic [31:0] mask;
        mask = {24'd0, len};
        if (burst == BURST_FIXED)
            return idx;
        if (burst == BURST_WRAP && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
            return (idx & ~mask) | ((idx + 32'd1) & mask);
        return idx + 32'd1;
    endfunction

    // ---------------- write channel ----------------
    w_state_t    w_state, w_next;
    logic [31:0] w_idx;
    logic [7:0]  w_len, w_cnt;
    logic [1:0]  w_burst;
    logic        w_err;
    logic [1:0]  bresp;
    logic        w_beat, w_in_range, w_err_n, w_done;

    assign w_beat     = (w_state == W_DATA) && S_AXI_WVALID;
    assign w_in_range = w_idx < DEPTH_W;
    assign w_err_n    = w_err | ~w_in_range;
    assign w_done     = S_AXI_WLAST || (w_cnt == w_len);

    always_ff @(posedge CLK) begin
        if (RST) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next        = w_state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        case (w_state)
            W_IDLE: begin
                S_AXI_AWREADY = 1'b1;
                if (S_AXI_AWVALID) w_next = W_DATA;
            end
            W_DATA: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && w_done) w_next = W_RESP;
            end
            W_RESP: begin
                S_AXI_BVALID = 1'b1;
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            w_idx   <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_err   <= 1'b0;
            bresp   <= RESP_OKAY;
        end else if (w_state == W_IDLE && S_AXI_AWVALID) begin
            w_idx   <= S_AXI_AWADDR >> OFFS;
            w_len   <= S_AXI_AWLEN;
            w_burst <= S_AXI_AWBURST;
            w_cnt   <= '0;
            w_err   <= 1'b0;
        end else if (w_beat) begin
            w_err <= w_err_n;
            if (w_done) begin
                bresp <= w_err_n ? RESP_SLVERR : RESP_OKAY;
            end else begin
                w_idx <= next_idx(w_idx, w_len, w_burst);
                w_cnt <= w_cnt + 8'd1;
            end
        end
    end

    assign S_AXI_BRESP = bresp;

    // Backdoor load is written last so it overrides a same-word AXI beat.
    always_ff @(posedge CLK) begin
        if (w_beat && w_in_range && !RST) begin
            for (int b = 0; b < SB; b++) begin
                if (S_AXI_WSTRB[b]) mem[w_idx[AW-1:0]][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
            end
        end
        if (LOAD_EN) mem[LOAD_ADDR] <= LOAD_DATA;
    end

    // ---------------- read channel ----------------
    r_state_t                    r_state, r_next;
    logic [31:0]                 r_idx, r_nidx, ar_idx, fetch_idx;
    logic [7:0]                  r_len, r_cnt;
    logic [1:0]                  r_burst;
    logic [2:0]                  r_wait;
    logic [C_AXI_DATA_WIDTH-1:0] rdata, fetch_dat;
    logic [1:0]                  rresp, fetch_resp;
    logic                        rlast, fetch_ok;

    assign ar_idx = S_AXI_ARADDR >> OFFS;
    assign r_nidx = next_idx(r_idx, r_len, r_burst);

    always_comb begin
        fetch_idx = r_nidx;
        if (r_state == R_IDLE)      fetch_idx = ar_idx;
        else if (r_state == R_WAIT) fetch_idx = r_idx;
    end

    // The memory is sampled at the same edge that writes it, so a colliding read sees old data.
    assign fetch_ok   = fetch_idx < DEPTH_W;
    assign fetch_dat  = fetch_ok ? mem[fetch_idx[AW-1:0]] : '0;
    assign fetch_resp = fetch_ok ? RESP_OKAY : RESP_SLVERR;

    always_ff @(posedge CLK) begin
        if (RST) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next        = r_state;
        S_AXI_ARREADY = 1'b0;
        S_AXI_RVALID  = 1'b0;
        case (r_state)
            R_IDLE: begin
                S_AXI_ARREADY = 1'b1;
                if (S_AXI_ARVALID) r_next = (C_RD_LATENCY == 1) ? R_DATA : R_WAIT;
            end
            R_WAIT: begin
                if (r_wait == 3'd0) r_next = R_DATA;
            end
            R_DATA: begin
                S_AXI_RVALID = 1'b1;
                if (S_AXI_RREADY && rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_idx   <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_wait  <= '0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            rlast   <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (S_AXI_ARVALID) begin
                        r_idx   <= ar_idx;
                        r_len   <= S_AXI_ARLEN;
                        r_burst <= S_AXI_ARBURST;
                        r_cnt   <= '0;
                        r_wait  <= WAIT_INIT;
                        if (C_RD_LATENCY == 1) begin
                            rdata <= fetch_dat;
                            rresp <= fetch_resp;
                            rlast <= (S_AXI_ARLEN == 8'd0);
                        end
                    end
                end
                R_WAIT: begin
                    if (r_wait == 3'd0) begin
                        rdata <= fetch_dat;
                        rresp <= fetch_resp;
                        rlast <= (r_len == 8'd0);
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end
                R_DATA: begin
                    if (S_AXI_RREADY) begin
                        if (rlast) begin
                            rlast <= 1'b0;
                        end else begin
                            r_idx <= r_nidx;
                            r_cnt <= r_cnt + 8'd1;
                            rdata <= fetch_dat;
                            rresp <= fetch_resp;
                            rlast <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign S_AXI_RDATA = rdata;
    assign S_AXI_RRESP = rresp;
    assign S_AXI_RLAST = rlast;

endmodule
